// File: rtl/banco_pkg.sv
// Shared types and helpers for the parametrised register file and its clear sequencer.
package banco_pkg;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  // Replicated to build an all-zero word of any width: {WIDTH{ZERO_BIT}}.
  localparam logic ZERO_BIT = 1'b0;

  // Index width for a file of `depth` registers; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/banco_init_seq.sv
// Clear sequencer: after reset, walks every register index once, writing zero, then raises pronto.
module banco_init_seq
  import banco_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pronto,
  output logic          init_we,
  output logic [AW-1:0] init_idx
);

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] counter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      counter <= '0;
    end else begin
      state <= next_state;
      if (state == S_INIT) begin
        counter <= counter + AW'(1);
      end
    end
  end

  // The last clear write and the move to S_READY share the same edge.
  always_comb begin
    next_state = state;
    if (state == S_INIT && counter == AW'(DEPTH - 1)) begin
      next_state = S_READY;
    end
  end

  // Writes are suppressed while rst is high so a restart never leaves a stray clear mid-array.
  always_comb begin
    pronto   = (state == S_READY);
    init_we  = (state == S_INIT) && !rst;
    init_idx = counter;
  end

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised MIPS-style register file: NUM_RD async read ports, one sync write port, self-clearing.
// Define BANCO_BYPASS_EN to forward same-cycle write data to matching read ports.
module banco_registradores_param
  import banco_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RegWrite,
  input  logic [AW-1:0]           Numero_Reg_Escrita,
  input  logic [WIDTH-1:0]        Dado_escrita,
  input  logic [NUM_RD*AW-1:0]    Numero_Reg,
  output logic [NUM_RD*WIDTH-1:0] Valor_Reg,
  output logic                    pronto
);

  logic [WIDTH-1:0] regs [DEPTH];

  logic             init_we;
  logic [AW-1:0]    init_idx;
  logic             ext_zero_hit;
  logic             ext_we;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  banco_init_seq #(
    .DEPTH(DEPTH)
  ) u_init_seq (
    .clk     (clk),
    .rst     (rst),
    .pronto  (pronto),
    .init_we (init_we),
    .init_idx(init_idx)
  );

  assign ext_zero_hit = (ZERO_REG != 0) && (Numero_Reg_Escrita == '0);
  // External writes arriving before the clear finishes are dropped, not queued.
  assign ext_we       = RegWrite && pronto && !rst && !ext_zero_hit;

  always_comb begin
    wr_en   = ext_we;
    wr_idx  = Numero_Reg_Escrita;
    wr_data = Dado_escrita;
    if (init_we) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx;
      wr_data = {WIDTH{ZERO_BIT}};
    end
  end

  // Storage carries no reset; the sequencer clears it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    rd_idx;
    logic             rd_zero_hit;
    logic [WIDTH-1:0] rd_val;

    assign rd_idx      = Numero_Reg[p*AW +: AW];
    assign rd_zero_hit = (ZERO_REG != 0) && (rd_idx == '0);

    always_comb begin
      rd_val = regs[rd_idx];
      if (rd_zero_hit) begin
        rd_val = {WIDTH{ZERO_BIT}};
      end
`ifdef BANCO_BYPASS_EN
      if (RegWrite && pronto && !rd_zero_hit && rd_idx == Numero_Reg_Escrita) begin
        rd_val = Dado_escrita;
      end
`endif
      if (!pronto) begin
        rd_val = {WIDTH{ZERO_BIT}};
      end
    end

    assign Valor_Reg[p*WIDTH +: WIDTH] = rd_val;
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Scoreboard bench for banco_registradores_param: directed vectors on a ZERO_REG=1 and a ZERO_REG=0 instance.
module tb_banco_registradores_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int WATCHDOG_CYCLES = 2000;
`ifdef BANCO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             reg_write;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    ra0, ra1;
  logic [2*WIDTH-1:0] val_a, val_b;
  logic             pronto_a, pronto_b;
  bit               done = 1'b0;

  always #5 clk = ~clk;

  banco_registradores_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(2), .ZERO_REG(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .RegWrite          (reg_write),
    .Numero_Reg_Escrita(wr_idx),
    .Dado_escrita      (wr_data),
    .Numero_Reg        ({ra1, ra0}),
    .Valor_Reg         (val_a),
    .pronto            (pronto_a)
  );

  banco_registradores_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(2), .ZERO_REG(0)
  ) dut_z (
    .clk               (clk),
    .rst               (rst),
    .RegWrite          (reg_write),
    .Numero_Reg_Escrita(wr_idx),
    .Dado_escrita      (wr_data),
    .Numero_Reg        ({ra1, ra0}),
    .Valor_Reg         (val_b),
    .pronto            (pronto_b)
  );

  // sel: 0 = dut port0, 1 = dut port1, 2 = dut pronto, 3 = dut_z port0
  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = val_a[31:0];
        1:       act = val_a[63:32];
        2:       act = {31'b0, pronto_a};
        default: act = val_b[31:0];
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    repeat (WATCHDOG_CYCLES) @(posedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL watchdog: wait expired after %0d cycles", WATCHDOG_CYCLES);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; reg_write = 1'b0; wr_idx = '0; wr_data = '0; ra0 = '0; ra1 = '0;
    tick();
    checks++;
    if (pronto_a !== 1'b0 || pronto_b !== 1'b0 || val_a !== '0 || val_b !== '0) begin
      errors++;
      $display("FAIL reset_state: pronto_a=%b pronto_b=%b val_a=%h val_b=%h",
               pronto_a, pronto_b, val_a, val_b);
    end
    expect_v(2, 32'd0, "rst_pronto");
    expect_v(0, 32'd0, "rst_val0");
    tick();

    // Clear sequence with a write to r7 held active the whole time: it must be dropped.
    rst = 1'b0;
    reg_write = 1'b1; wr_idx = 5'd7; wr_data = 32'h55; ra0 = 5'd7; ra1 = 5'd7;
    expect_v(2, 32'd0, "init_pronto_c0");
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      if (c == DEPTH) reg_write = 1'b0;
      expect_v(2, (c == DEPTH) ? 32'd1 : 32'd0, $sformatf("init_pronto_c%0d", c));
      expect_v(0, 32'd0, $sformatf("init_val_c%0d", c));
    end

    for (int i = 0; i < DEPTH; i++) begin
      ra0 = AW'(i); ra1 = AW'(DEPTH - 1 - i);
      expect_v(0, 32'd0, $sformatf("clear_p0_r%0d", i));
      expect_v(1, 32'd0, $sformatf("clear_p1_r%0d", DEPTH - 1 - i));
      if (i == 0) expect_v(3, 32'd0, "clear_z_r0");
      tick();
    end

    // Write r5, visible on both ports next cycle.
    reg_write = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEADBEEF; ra0 = 5'd5; ra1 = 5'd5;
    expect_v(0, BYP ? 32'hDEADBEEF : 32'd0, "r5_same_cycle");
    tick();
    reg_write = 1'b0;
    expect_v(0, 32'hDEADBEEF, "r5_p0");
    expect_v(1, 32'hDEADBEEF, "r5_p1");
    tick();

    // r0 write: hardwired zero on dut, ordinary on dut_z.
    reg_write = 1'b1; wr_idx = 5'd0; wr_data = 32'h1234; ra0 = 5'd0; ra1 = 5'd0;
    expect_v(0, 32'd0, "r0_zero_same");
    expect_v(3, BYP ? 32'h1234 : 32'd0, "r0_plain_same");
    tick();
    reg_write = 1'b0;
    expect_v(0, 32'd0, "r0_zero_p0");
    expect_v(1, 32'd0, "r0_zero_p1");
    expect_v(3, 32'h1234, "r0_plain");
    tick();

    // Same-cycle write/read of r9.
    reg_write = 1'b1; wr_idx = 5'd9; wr_data = 32'h77; ra0 = 5'd9; ra1 = 5'd5;
    expect_v(0, BYP ? 32'h77 : 32'd0, "r9_same_cycle");
    expect_v(1, 32'hDEADBEEF, "r5_unaffected");
    tick();
    reg_write = 1'b0;
    expect_v(0, 32'h77, "r9_next");
    tick();

    // r3 = 0xAA, then reset mid-clear at cycle 10 and confirm a full restart.
    reg_write = 1'b1; wr_idx = 5'd3; wr_data = 32'hAA;
    tick();
    reg_write = 1'b0; ra0 = 5'd3;
    expect_v(0, 32'hAA, "r3_written");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      expect_v(2, 32'd0, $sformatf("rst1_pronto_c%0d", c));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_v(2, 32'd0, "rst2_pronto_c0");
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      expect_v(2, (c == DEPTH) ? 32'd1 : 32'd0, $sformatf("rst2_pronto_c%0d", c));
    end
    ra0 = 5'd3; ra1 = 5'd5;
    expect_v(0, 32'd0, "r3_cleared");
    expect_v(1, 32'd0, "r5_cleared");
    tick();
    tick();
    tick();

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
